sw_operand_loader: RTL and testbench

Parametrised operand front-end for the multiplier datapath. It captures one or two operands from a switch bank on a debounced load-button press and presents them to the multiplier through a valid/ready handshake. Width, debounce length and load mode (single-shot or sequential) are configurable. It sits between the board switch/button inputs and the multiplier core.

---
 rtl/sw_operand_loader.sv | 126 ++++++++++++
 tb/tb_sw_operand_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sw_operand_loader.sv
// sw_operand_loader: captures multiplier/multiplicand operands from a switch
// bank on a debounced load-button press and offers them to the multiplier
// core over a valid/ready handshake. Supports single-shot and two-press loads.
module sw_operand_loader #(
    parameter int DW  = 8,
    parameter int DEB = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2*DW-1:0] i_sw,
    input  logic            i_load,
    input  logic            i_mode,
    input  logic            i_ready,
    output logic [DW-1:0]   o_multiplier,
    output logic [DW-1:0]   o_multiplicand,
    output logic            o_valid,
    output logic [1:0]      o_state
);

    localparam int            CW       = $clog2(DEB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_B = 2'b01,
        ST_VALID  = 2'b10
    } state_t;

    logic          r_s1, r_s2;
    logic          r_stable, r_stable_d;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    state_t        r_state, w_state_nxt;
    logic          w_cap_a, w_cap_b;
    logic [DW-1:0] r_mult, r_mcand;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_load;
            r_s2 <= r_s1;
        end
    end

    // Debouncer: a new level must hold for DEB consecutive cycles before it is accepted
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Registered one-cycle press pulse on the debounced rising edge; release makes no pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and capture strobes; presses while VALID are dropped, not queued
    always_comb begin
        w_state_nxt = r_state;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_press) begin
                    w_cap_a = 1'b1;
                    if (i_mode) begin
                        w_state_nxt = ST_WAIT_B;
                    end else begin
                        w_cap_b     = 1'b1;
                        w_state_nxt = ST_VALID;
                    end
                end
            end
            ST_WAIT_B: begin
                if (r_press) begin
                    w_cap_b     = 1'b1;
                    w_state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (i_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand registers: hold last value until overwritten by a capture
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mult  <= '0;
            r_mcand <= '0;
        end else begin
            if (w_cap_a) r_mult  <= i_sw[DW-1:0];
            if (w_cap_b) r_mcand <= i_sw[2*DW-1:DW];
        end
    end

    assign o_multiplier   = r_mult;
    assign o_multiplicand = r_mcand;
    assign o_valid        = (r_state == ST_VALID);
    assign o_state        = r_state;

endmodule

// File: tb/tb_sw_operand_loader.sv
// Directed self-checking bench for sw_operand_loader: one instance at
// DW=8/DEB=4 for the main scenarios and one at DW=16/DEB=1 for the sweep.
module tb_sw_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic        load = 1'b0, mode = 1'b0, ready = 1'b0;
    logic [7:0]  mult, mcand;
    logic        valid;
    logic [1:0]  state;

    logic [31:0] sw1 = '0;
    logic        load1 = 1'b0, mode1 = 1'b0, ready1 = 1'b0;
    logic [15:0] mult1, mcand1;
    logic        valid1;
    logic [1:0]  state1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sw_operand_loader #(.DW(8), .DEB(4)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_sw(sw), .i_load(load), .i_mode(mode),
        .i_ready(ready), .o_multiplier(mult), .o_multiplicand(mcand),
        .o_valid(valid), .o_state(state)
    );

    sw_operand_loader #(.DW(16), .DEB(1)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_sw(sw1), .i_load(load1), .i_mode(mode1),
        .i_ready(ready1), .o_multiplier(mult1), .o_multiplicand(mcand1),
        .o_valid(valid1), .o_state(state1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge and settle 1 time unit past it
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_mult", 32'(mult), 32'h00);
        chk("rst_mcand", 32'(mcand), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // mode 0: press latency, capture, handshake
        sw = 16'h0503; mode = 1'b0; load = 1'b1;
        tick(7);
        chk("m0_valid_e7", 32'(valid), 32'h0);
        tick(1);
        chk("m0_valid_e8", 32'(valid), 32'h1);
        chk("m0_state_e8", 32'(state), 32'h2);
        chk("m0_mult", 32'(mult), 32'h03);
        chk("m0_mcand", 32'(mcand), 32'h05);
        ready = 1'b1;
        tick(1);
        chk("m0_valid_done", 32'(valid), 32'h0);
        chk("m0_state_done", 32'(state), 32'h0);
        ready = 1'b0;
        load = 1'b0;
        tick(10);

        // debounce: 3-cycle glitch is rejected
        sw = 16'hFFFF;
        load = 1'b1; tick(3); load = 1'b0;
        tick(12);
        chk("glitch_state", 32'(state), 32'h0);
        chk("glitch_mult", 32'(mult), 32'h03);
        chk("glitch_mcand", 32'(mcand), 32'h05);

        // debounce: 4-cycle pulse gives exactly one capture
        sw = 16'h1122;
        load = 1'b1; tick(4); load = 1'b0;
        tick(4);
        chk("pulse_valid", 32'(valid), 32'h1);
        chk("pulse_mult", 32'(mult), 32'h22);
        chk("pulse_mcand", 32'(mcand), 32'h11);
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("pulse_done", 32'(state), 32'h0);
        tick(12);
        chk("pulse_single", 32'(state), 32'h0);

        // mode 1: two presses
        sw = 16'h00A7; mode = 1'b1; ready = 1'b1;  // ready ignored outside VALID
        load = 1'b1; tick(8);
        chk("m1_p1_state", 32'(state), 32'h1);
        chk("m1_p1_mult", 32'(mult), 32'hA7);
        chk("m1_p1_valid", 32'(valid), 32'h0);
        chk("m1_p1_mcand", 32'(mcand), 32'h11);
        load = 1'b0; ready = 1'b0; tick(10);
        chk("m1_wait_hold", 32'(state), 32'h1);
        sw = 16'h3C00; mode = 1'b0;  // mode change in WAIT_B ignored
        load = 1'b1; tick(8);
        chk("m1_p2_state", 32'(state), 32'h2);
        chk("m1_p2_valid", 32'(valid), 32'h1);
        chk("m1_p2_mcand", 32'(mcand), 32'h3C);
        chk("m1_p2_mult", 32'(mult), 32'hA7);
        load = 1'b0;

        // back-pressure: extra press and switch churn while VALID
        for (int i = 0; i < 24; i++) begin
            load = (i < 8);
            sw = 16'(i * 16'h1357 + 16'h0101);
            tick(1);
            chk("bp_valid", 32'(valid), 32'h1);
        end
        chk("bp_mult", 32'(mult), 32'hA7);
        chk("bp_mcand", 32'(mcand), 32'h3C);

        // press coincident with the transfer edge is dropped
        sw = 16'h9988;
        load = 1'b1; tick(7);
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("coinc_state", 32'(state), 32'h0);
        chk("coinc_mult", 32'(mult), 32'hA7);
        chk("coinc_mcand", 32'(mcand), 32'h3C);
        tick(3);
        chk("coinc_noqueue", 32'(state), 32'h0);
        load = 1'b0; tick(10);

        // asynchronous reset mid-WAIT_B
        sw = 16'h5566; mode = 1'b1;
        load = 1'b1; tick(8); load = 1'b0;
        chk("wb_state", 32'(state), 32'h1);
        chk("wb_mult", 32'(mult), 32'h66);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mult", 32'(mult), 32'h00);
        chk("arst_mcand", 32'(mcand), 32'h00);
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_state", 32'(state), 32'h0);
        #2 rst_n = 1'b1;
        tick(6);
        chk("post_rst_state", 32'(state), 32'h0);
        chk("post_rst_valid", 32'(valid), 32'h0);

        // sweep instance DW=16, DEB=1, ready already high
        sw1 = 32'hBEEF_1234; mode1 = 1'b0; ready1 = 1'b1; load1 = 1'b1;
        tick(4);
        chk("sw_valid_e4", 32'(valid1), 32'h0);
        tick(1);
        chk("sw_valid_e5", 32'(valid1), 32'h1);
        chk("sw_mult", 32'(mult1), 32'h1234);
        chk("sw_mcand", 32'(mcand1), 32'hBEEF);
        tick(1);
        chk("sw_valid_1cyc", 32'(valid1), 32'h0);
        chk("sw_state", 32'(state1), 32'h0);
        load1 = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
